// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals shared by the UART transmit arbiter.
// The master side is the requesters plus the transmitter; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 err;
    logic [NUM_REQ-1:0]   grant;
    logic                 baud_tick;
    logic                 Tx_EN;
    logic                 Tx_BUSY;
    logic [7:0]           tx_data;

    modport master (
        output req, req_data, baud_tick, Tx_BUSY,
        input  ack, err, grant, Tx_EN, tx_data
    );

    modport slave (
        input  req, req_data, baud_tick, Tx_BUSY,
        output ack, err, grant, Tx_EN, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// It holds Tx_EN for a whole frame, then acknowledges the requester or flags a stuck transmitter.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        SEND    = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        winner_q, winner_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_flag_q, err_flag_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;

    logic                 found_s;
    logic [PW-1:0]        pick_s;
    logic [PW-1:0]        ptr_next_s;
    logic                 timeout_s;
    int                   idx_s;

    // Round-robin search: first asserted request at or above ptr, wrapping around.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = (int'(ptr_q) + k) % NUM_REQ;
            if (!found_s && bus.req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = PW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
        ptr_next_s = PW'((int'(pick_s) + 1) % NUM_REQ);
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        timeout_s  = bus.baud_tick && (cnt_q == CW'(TIMEOUT_TICKS - 1));

        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d   = LAUNCH;
                    winner_d  = pick_s;
                    ptr_d     = ptr_next_s;
                    grant_d   = NUM_REQ'(1'b1) << pick_s;
                    tx_data_d = bus.req_data[8*int'(pick_s) +: 8];
                    cnt_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                if (bus.baud_tick) begin
                    cnt_d = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
                // A stuck transmitter takes precedence so the frame can never hang.
                if (timeout_s) begin
                    err_flag_d = 1'b1;
                    state_d    = RELEASE;
                end else if (bus.Tx_BUSY) begin
                    state_d = SEND;
                end else begin
                    state_d = LAUNCH;
                end
            end
            SEND: begin
                if (bus.baud_tick) begin
                    cnt_d = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (timeout_s) begin
                    err_flag_d = 1'b1;
                    state_d    = RELEASE;
                end else if (!bus.Tx_BUSY) begin
                    state_d = RELEASE;
                end else begin
                    state_d = SEND;
                end
            end
            RELEASE: begin
                if (bus.baud_tick) begin
                    state_d = DONE;
                end else begin
                    state_d = RELEASE;
                end
            end
            DONE: begin
                grant_d    = '0;
                err_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                err_flag_d = 1'b0;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        tx_en_d = (state_d == LAUNCH) || (state_d == SEND);
        ack_d   = (state_d == DONE) ? (NUM_REQ'(1'b1) << winner_d) : '0;
        err_d   = (state_d == DONE) ? err_flag_d : 1'b0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            winner_q   <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            grant_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign bus.Tx_EN   = tx_en_q;
    assign bus.grant   = grant_q;
    assign bus.tx_data = tx_data_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the bench itself plays the role of the UART transmitter.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_TICKS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_launch();
        int n;
        n = 0;
        while (bus.Tx_EN !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("launch", 32'(bus.Tx_EN), 32'd1);
    endtask

    // One normal frame: start + 8 data + parity while busy, then stop bit and release.
    task automatic serve(input int idx, input logic [7:0] data, input logic [3:0] clr);
        wait_launch();
        chk("grant", 32'(bus.grant), 32'd1 << idx);
        chk("tx_data", 32'(bus.tx_data), 32'(data));
        bus.req_data[8*idx +: 8] = ~data;
        bus.baud_tick = 1'b1;
        bus.Tx_BUSY   = 1'b1;
        step();
        repeat (9) step();
        chk("hold_en", 32'(bus.Tx_EN), 32'd1);
        bus.Tx_BUSY = 1'b0;
        step();
        chk("release_en", 32'(bus.Tx_EN), 32'd0);
        chk("release_grant", 32'(bus.grant), 32'd1 << idx);
        chk("release_ack", 32'(bus.ack), 32'd0);
        bus.baud_tick = 1'b0;
        step();
        chk("wait_ack", 32'(bus.ack), 32'd0);
        bus.baud_tick = 1'b1;
        step();
        chk("ack", 32'(bus.ack), 32'd1 << idx);
        chk("err", 32'(bus.err), 32'd0);
        chk("tx_data_held", 32'(bus.tx_data), 32'(data));
        bus.req_data[8*idx +: 8] = data;
        bus.req = bus.req & ~clr;
        bus.baud_tick = 1'b0;
        step();
        chk("ack_pulse", 32'(bus.ack), 32'd0);
        chk("grant_idle", 32'(bus.grant), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.req       = 4'b0000;
        bus.req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.baud_tick = 1'b0;
        bus.Tx_BUSY   = 1'b0;
        step();
        step();
        chk("rst_en", 32'(bus.Tx_EN), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        reset = 1'b1;
        step();

        // Single requester 2 with byte A5; also checks data stability after grant.
        bus.req = 4'b0100;
        serve(2, 8'hA5, 4'b0100);

        // All requesters held from reset: strict rotation 0,1,2,3,0.
        reset   = 1'b0;
        bus.req = 4'b1111;
        step();
        step();
        reset = 1'b1;
        serve(0, 8'h11, 4'b0000);
        serve(1, 8'h22, 4'b0000);
        serve(2, 8'hA5, 4'b0000);
        serve(3, 8'h44, 4'b0000);
        serve(0, 8'h11, 4'b1111);

        // Last grant was 1, so requester 3 outranks requester 1.
        bus.req = 4'b0010;
        serve(1, 8'h22, 4'b0010);
        bus.req = 4'b1010;
        serve(3, 8'h44, 4'b1000);
        serve(1, 8'h22, 4'b0010);

        // Transmitter never goes busy: abort after 16 baud ticks with err.
        bus.req = 4'b0001;
        wait_launch();
        chk("to_grant", 32'(bus.grant), 32'd1);
        chk("to_data", 32'(bus.tx_data), 32'h11);
        bus.baud_tick = 1'b1;
        bus.Tx_BUSY   = 1'b0;
        repeat (15) step();
        chk("to_pre_en", 32'(bus.Tx_EN), 32'd1);
        step();
        chk("to_en", 32'(bus.Tx_EN), 32'd0);
        chk("to_early_ack", 32'(bus.ack), 32'd0);
        step();
        chk("to_ack", 32'(bus.ack), 32'd1);
        chk("to_err", 32'(bus.err), 32'd1);
        bus.req       = 4'b0000;
        bus.baud_tick = 1'b0;
        step();
        chk("to_ack_clr", 32'(bus.ack), 32'd0);
        chk("to_err_clr", 32'(bus.err), 32'd0);

        // Reset in the middle of SEND: no ack, pointer back to 0.
        bus.req = 4'b0100;
        wait_launch();
        chk("mr_grant", 32'(bus.grant), 32'd4);
        bus.baud_tick = 1'b1;
        bus.Tx_BUSY   = 1'b1;
        step();
        bus.baud_tick = 1'b0;
        step();
        chk("mr_send_en", 32'(bus.Tx_EN), 32'd1);
        reset = 1'b0;
        step();
        chk("mr_en", 32'(bus.Tx_EN), 32'd0);
        chk("mr_grant0", 32'(bus.grant), 32'd0);
        chk("mr_ack", 32'(bus.ack), 32'd0);
        chk("mr_data", 32'(bus.tx_data), 32'd0);
        bus.req     = 4'b0101;
        bus.Tx_BUSY = 1'b0;
        step();
        chk("mr_ack2", 32'(bus.ack), 32'd0);
        reset = 1'b1;
        serve(0, 8'h11, 4'b0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
